wb_lcd_fetch: RTL and testbench

Wishbone B3 burst-read master that streams a framebuffer from off-chip SDRAM to the LCD pixel pipeline. It sits outside the processor subsystem and drives the processor's LCD-side Wishbone port, which arbitrates against the CPU for SDRAM. It fetches `FRAME_WORDS` 32-bit words per frame from `fb_base` in linear incrementing bursts and buffers them in a first-word-fall-through FIFO for the pixel clock-enable side.

---
 rtl/lcd_fetch_pkg.sv | 14 +
 rtl/wishbone_b3.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/wb_lcd_fetch.sv | 135 +++++++++++++
 tb/tb_wb_lcd_fetch.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_fetch_pkg.sv
// Shared types and Wishbone burst encodings for the LCD framebuffer fetcher.
package lcd_fetch_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BURST,
        ST_DRAIN
    } fetch_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
endpackage

// File: rtl/wishbone_b3.sv
// 32-bit Wishbone B3 bus bundle with registered-feedback burst tags.
interface wishbone_b3;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m2s;
    logic [31:0] dat_s2m;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_m2s, cti, bte,
        input  dat_s2m, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m2s, cti, bte,
        output dat_s2m, ack, err, rty
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (count != FULL || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    // the fetcher only issues a burst when the whole burst fits
    always_ff @(posedge clk) begin
        if (rst_n && !flush)
            assert (!(push && count == FULL && !pop));
    end
endmodule

// File: rtl/wb_lcd_fetch.sv
// Wishbone B3 burst-read master streaming a framebuffer into the
// pixel FIFO; one frame of FRAME_WORDS words per frame_start.
module wb_lcd_fetch #(
    parameter int FIFO_DEPTH  = 16,
    parameter int BURST_LEN   = 8,
    parameter int FRAME_WORDS = 38400
) (
    input  logic        clk,
    input  logic        rst,
    wishbone_b3.master  wb,
    input  logic [31:0] fb_base,
    input  logic        frame_start,
    input  logic        pix_rd,
    output logic [31:0] pix_data,
    output logic        pix_valid,
    output logic        underrun,
    output logic        bus_error
);
    import lcd_fetch_pkg::*;

    localparam int RW = $clog2(FRAME_WORDS + 1);
    localparam int LW = $clog2(BURST_LEN + 1);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   ptr;
    logic [RW-1:0] remaining;
    logic [LW-1:0] beats_left;
    logic [LW-1:0] len;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          cyc;
    logic          stb;
    logic [31:0]   adr;
    logic [2:0]    cti;
    logic          beat_done;
    logic          last;
    logic          push;
    logic          empty;

    assign wb.cyc     = cyc;
    assign wb.stb     = stb;
    assign wb.adr     = adr;
    assign wb.cti     = cti;
    assign wb.we      = 1'b0;
    assign wb.sel     = 4'hF;
    assign wb.dat_m2s = '0;
    assign wb.bte     = BTE_LINEAR;

    assign len       = (remaining < RW'(BURST_LEN)) ? LW'(remaining)
                                                    : LW'(BURST_LEN);
    assign free      = CW'(FIFO_DEPTH) - count;
    assign beat_done = cyc && stb && (wb.ack || wb.err);
    assign last      = (beats_left == LW'(1));
    assign push      = (state == ST_BURST) && beat_done && !frame_start;
    assign pix_valid = !empty;

    sync_fifo_fwft #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (frame_start),
        .push      (push),
        .push_data (wb.err ? 32'h0 : wb.dat_s2m),
        .pop       (pix_rd),
        .pop_data  (pix_data),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            remaining  <= '0;
            beats_left <= '0;
            cyc        <= 1'b0;
            stb        <= 1'b0;
            adr        <= '0;
            cti        <= CTI_CLASSIC;
            underrun   <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            if (pix_rd && !pix_valid) underrun <= 1'b1;
            if (beat_done && wb.err) bus_error <= 1'b1;

            // a retried beat is re-presented after one idle strobe cycle
            if (cyc && !stb) stb <= 1'b1;
            else if (stb && wb.rty) stb <= 1'b0;

            unique case (state)
                ST_IDLE: ;
                ST_REQ: begin
                    if (frame_start) begin
                    end else if (remaining == '0) begin
                        state <= ST_IDLE;
                    end else if (free >= CW'(len)) begin
                        state      <= ST_BURST;
                        cyc        <= 1'b1;
                        stb        <= 1'b1;
                        adr        <= ptr;
                        cti        <= (len == LW'(1)) ? CTI_END : CTI_INCR;
                        beats_left <= len;
                        ptr        <= ptr + (32'(len) << 2);
                        remaining  <= remaining - RW'(len);
                    end
                end
                ST_BURST, ST_DRAIN: begin
                    if (beat_done) begin
                        adr        <= adr + 32'd4;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == LW'(2)) cti <= CTI_END;
                        if (last || wb.err) begin
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            cti   <= CTI_CLASSIC;
                            state <= ST_REQ;
                        end
                    end
                end
            endcase

            if (frame_start) begin
                ptr       <= fb_base;
                remaining <= RW'(FRAME_WORDS);
                underrun  <= 1'b0;
                bus_error <= 1'b0;
                state     <= (cyc && !(beat_done && (last || wb.err)))
                             ? ST_DRAIN : ST_REQ;
            end
        end
    end
endmodule

// File: tb/tb_wb_lcd_fetch.sv
// Directed bench for wb_lcd_fetch with a behavioural Wishbone slave
// (optional random stalls, one-shot retry and error) and bus/pixel logs.
module tb_wb_lcd_fetch;
    localparam logic [31:0] B0 = 32'h0200_0000;
    localparam logic [31:0] B1 = 32'h0300_0000;
    localparam logic [31:0] B2 = 32'h0400_0000;
    localparam logic [31:0] B3 = 32'h0500_0000;
    localparam logic [31:0] B4 = 32'h0600_0000;
    localparam logic [31:0] B5 = 32'h0800_0000;
    localparam logic [31:0] B6 = 32'h0900_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fb_base = '0;
    logic        frame_start = 1'b0;
    logic        pix_rd = 1'b0;
    logic [31:0] pix_data;
    logic        pix_valid;
    logic        underrun;
    logic        bus_error;

    wishbone_b3 wb ();

    wb_lcd_fetch #(
        .FIFO_DEPTH  (16),
        .BURST_LEN   (8),
        .FRAME_WORDS (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb),
        .fb_base     (fb_base),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underrun    (underrun),
        .bus_error   (bus_error)
    );

    always #5 clk = ~clk;

    logic        stall = 1'b0;
    logic        ack_en = 1'b1;
    logic        req;
    int          rty_beat = 0;
    int          err_beat = 0;
    int          rty_lim = 0;
    int          err_lim = 0;
    int          n_rty = 0;
    int          n_err = 0;
    int          sbeat = 0;
    int          cyc_n = 0;
    logic [31:0] rty_adr = '0;

    assign req        = wb.cyc && wb.stb;
    assign wb.rty     = req && (n_rty < rty_lim) && (sbeat == rty_beat - 1);
    assign wb.err     = req && (n_err < err_lim) && (sbeat == err_beat - 1);
    assign wb.ack     = req && ack_en && !wb.rty && !wb.err;
    assign wb.dat_s2m = ~wb.adr;

    always @(negedge clk) ack_en <= stall ? ($urandom_range(0, 2) != 0) : 1'b1;

    logic [31:0] log_adr[$];
    logic [31:0] log_cti[$];
    logic [31:0] log_err[$];
    int          log_cyc[$];
    logic [31:0] popped[$];

    always @(posedge clk) begin
        if (req && (wb.ack || wb.err)) begin
            log_adr.push_back(wb.adr);
            log_cti.push_back(32'(wb.cti));
            log_err.push_back(32'(wb.err));
            log_cyc.push_back(cyc_n);
        end
        if (req && wb.rty) begin
            rty_adr <= wb.adr;
            n_rty   <= n_rty + 1;
        end
        if (req && wb.err) n_err <= n_err + 1;
        if (!wb.cyc) sbeat <= 0;
        else if (req && (wb.ack || wb.err)) sbeat <= sbeat + 1;
        if (pix_rd && pix_valid) popped.push_back(pix_data);
        cyc_n <= cyc_n + 1;
    end

    function automatic logic [31:0] ladr(input int i);
        return (i < log_adr.size()) ? log_adr[i] : 'x;
    endfunction
    function automatic logic [31:0] lcti(input int i);
        return (i < log_cti.size()) ? log_cti[i] : 'x;
    endfunction
    function automatic logic [31:0] lerr(input int i);
        return (i < log_err.size()) ? log_err[i] : 'x;
    endfunction
    function automatic logic [31:0] lcyc(input int i);
        return (i < log_cyc.size()) ? 32'(log_cyc[i]) : 'x;
    endfunction
    function automatic logic [31:0] pword(input int i);
        return (i < popped.size()) ? popped[i] : 'x;
    endfunction

    int n_run = 0;
    int n_fail = 0;
    int lb = 0;
    int pb = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic [31:0] base);
        fb_base     = base;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_pops(input int n, input int budget);
        int t = 0;
        while (popped.size() - pb < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("pop_count", 32'(popped.size() - pb), 32'(n));
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t = 0;
        while (log_adr.size() - lb < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("beat_count", 32'(log_adr.size() - lb), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(wb.cyc), 32'd0);
        chk("rst_stb", 32'(wb.stb), 32'd0);
        chk("rst_we", 32'(wb.we), 32'd0);
        chk("rst_adr", wb.adr, 32'd0);
        chk("rst_sel", 32'(wb.sel), 32'hF);
        chk("rst_dat", wb.dat_m2s, 32'd0);
        chk("rst_cti", 32'(wb.cti), 32'd0);
        chk("rst_bte", 32'(wb.bte), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_buserr", 32'(bus_error), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // short frame, consumer always ready
        lb = log_adr.size();
        pb = popped.size();
        pix_rd = 1'b1;
        start_frame(B0);
        chk("sf_stb_n1", 32'(wb.stb), 32'd0);
        @(negedge clk);
        chk("sf_stb_n2", 32'(wb.stb), 32'd1);
        chk("sf_adr_n2", wb.adr, B0);
        wait_pops(20, 200);
        for (int i = 0; i < 20; i++) begin
            chk("sf_adr", ladr(lb + i), B0 + 32'(4 * i));
            chk("sf_cti", lcti(lb + i),
                (i == 7 || i == 15 || i == 19) ? 32'd7 : 32'd2);
            chk("sf_data", pword(pb + i), ~(B0 + 32'(4 * i)));
        end
        chk("sf_gap1", lcyc(lb + 8) - lcyc(lb + 7), 32'd2);
        chk("sf_gap2", lcyc(lb + 16) - lcyc(lb + 15), 32'd2);
        repeat (3) @(negedge clk);
        chk("sf_idle", 32'(wb.cyc), 32'd0);

        // stalled consumer
        pix_rd = 1'b0;
        lb = log_adr.size();
        pb = popped.size();
        start_frame(B1);
        repeat (40) @(negedge clk);
        chk("st_beats", 32'(log_adr.size() - lb), 32'd16);
        chk("st_cyc", 32'(wb.cyc), 32'd0);
        chk("st_valid", 32'(pix_valid), 32'd1);
        chk("st_head", pix_data, ~B1);
        pix_rd = 1'b1;
        @(negedge clk);
        pix_rd = 1'b0;
        repeat (10) @(negedge clk);
        chk("st_one_pop", 32'(log_adr.size() - lb), 32'd16);
        chk("st_one_cyc", 32'(wb.cyc), 32'd0);
        pix_rd = 1'b1;
        repeat (7) @(negedge clk);
        pix_rd = 1'b0;
        repeat (20) @(negedge clk);
        chk("st_refill", 32'(log_adr.size() - lb), 32'd20);
        chk("st_refill_adr", ladr(lb + 16), B1 + 32'h40);
        chk("st_last_cti", lcti(lb + 19), 32'd7);
        for (int i = 0; i < 8; i++)
            chk("st_data", pword(pb + i), ~(B1 + 32'(4 * i)));

        // underrun before first ack
        lb = log_adr.size();
        pix_rd = 1'b1;
        start_frame(B2);
        @(negedge clk);
        chk("ur_set", 32'(underrun), 32'd1);
        chk("ur_valid", 32'(pix_valid), 32'd0);
        pix_rd = 1'b0;
        repeat (30) @(negedge clk);
        chk("ur_sticky", 32'(underrun), 32'd1);

        // restart on beat 3 of a burst
        lb = log_adr.size();
        start_frame(B3);
        chk("ur_cleared", 32'(underrun), 32'd0);
        wait_beats(2, 20);
        fb_base     = B4;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (30) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("rs_adr", ladr(lb + i), B3 + 32'(4 * i));
            chk("rs_cti", lcti(lb + i), (i == 7) ? 32'd7 : 32'd2);
        end
        chk("rs_next_adr", ladr(lb + 8), B4);
        chk("rs_valid", 32'(pix_valid), 32'd1);
        chk("rs_head", pix_data, ~B4);
        pb = popped.size();
        pix_rd = 1'b1;
        wait_pops(20, 200);
        for (int i = 0; i < 20; i++)
            chk("rs_data", pword(pb + i), ~(B4 + 32'(4 * i)));

        // random stalls, retry on beat 2, error on beat 5
        lb = log_adr.size();
        pb = popped.size();
        stall    = 1'b1;
        rty_beat = 2;
        rty_lim  = n_rty + 1;
        err_beat = 5;
        err_lim  = n_err + 1;
        start_frame(B5);
        wait_pops(17, 600);
        stall = 1'b0;
        repeat (5) @(negedge clk);
        chk("er_flag", 32'(bus_error), 32'd1);
        chk("rty_adr", rty_adr, B5 + 32'h4);
        chk("rty_reissue", ladr(lb + 1), B5 + 32'h4);
        chk("er_is_err", lerr(lb + 4), 32'd1);
        chk("er_adr", ladr(lb + 4), B5 + 32'h10);
        chk("er_next_adr", ladr(lb + 5), B5 + 32'h20);
        chk("er_beats", 32'(log_adr.size() - lb), 32'd17);
        for (int i = 0, k = 0; i < 20; i++) begin
            if (i < 5 || i >= 8) begin
                chk("er_data", pword(pb + k),
                    (i == 4) ? 32'h0 : ~(B5 + 32'(4 * i)));
                k++;
            end
        end

        // asynchronous reset mid-burst
        lb = log_adr.size();
        start_frame(B6);
        chk("rr_berr_clr", 32'(bus_error), 32'd0);
        @(negedge clk);
        chk("rr_underrun", 32'(underrun), 32'd1);
        pix_rd = 1'b0;
        wait_beats(3, 20);
        chk("rr_pre_valid", 32'(pix_valid), 32'd1);
        chk("rr_pre_cyc", 32'(wb.cyc), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rr_cyc", 32'(wb.cyc), 32'd0);
        chk("rr_stb", 32'(wb.stb), 32'd0);
        chk("rr_adr", wb.adr, 32'd0);
        chk("rr_cti", 32'(wb.cti), 32'd0);
        chk("rr_valid", 32'(pix_valid), 32'd0);
        chk("rr_underrun_clr", 32'(underrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rr_idle_cyc", 32'(wb.cyc), 32'd0);
        chk("rr_idle_valid", 32'(pix_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
